// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: fetch-side instruction, write-back port, forwarding-unit
// destinations, and the registered ID/EX fields handed to execute.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
);
    logic              flush;
    logic              stall;
    logic              in_valid;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] pc_in;
    logic [3:0]        status;
    logic              wb_wb_en;
    logic [RA_W-1:0]   wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              exe_wb_en;
    logic [RA_W-1:0]   exe_dest;
    logic              mem_wb_en;
    logic [RA_W-1:0]   mem_dest;
    logic              hazard;
    logic [8:0]        ctrl_out;
    logic              out_valid;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [RA_W-1:0]   dest;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm;
    logic [DATA_W-1:0] pc_out;

    modport master (
        output flush, stall, in_valid, instruction, pc_in, status,
               wb_wb_en, wb_dest, wb_value, exe_wb_en, exe_dest, mem_wb_en, mem_dest,
        input  hazard, ctrl_out, out_valid, val_rn, val_rm, dest, imm,
               shift_operand, signed_imm, pc_out
    );

    modport slave (
        input  flush, stall, in_valid, instruction, pc_in, status,
               wb_wb_en, wb_dest, wb_value, exe_wb_en, exe_dest, mem_wb_en, mem_dest,
        output hazard, ctrl_out, out_valid, val_rn, val_rm, dest, imm,
               shift_operand, signed_imm, pc_out
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file, condition check, control decode,
// RAW hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_N     = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_pipe_if.slave bus
);
    localparam int RA_W = $clog2(REG_N);

    typedef enum logic [1:0] {MODE_DP = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10, MODE_NONE = 2'b11} mode_e;

    typedef struct packed {
        logic       s;
        logic       b;
        logic [3:0] exe_cmd;
        logic       mem_w;
        logic       mem_r;
        logic       wb_en;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic              valid;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [RA_W-1:0]   dest;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm;
        logic [DATA_W-1:0] pc;
    } idex_t;

    logic [DATA_W-1:0] rf_q [REG_N];
    idex_t             idex_q, idex_d;
    ctrl_t             ctrl_dec;
    logic              use_src1, use_src2, cond_ok;
    logic [RA_W-1:0]   src1, src2;
    logic [DATA_W-1:0] rd1, rd2;
    logic              hazard;

    wire [31:0] instr  = bus.instruction;
    wire [3:0]  opcode = instr[24:21];
    wire        n_f = bus.status[3];
    wire        z_f = bus.status[2];
    wire        c_f = bus.status[1];
    wire        v_f = bus.status[0];

    // Condition field evaluated against the current {N,Z,C,V} flags.
    always_comb begin
        cond_ok = 1'b0;
        case (instr[31:28])
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !c_f || z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = z_f || (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Control decode and source-usage flags from mode/opcode.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl_dec = '0;
        use_src1 = 1'b1;
        use_src2 = 1'b0;
        case (mode_e'(instr[27:26]))
            MODE_DP: begin
                ctrl_dec.s     = instr[20];
                ctrl_dec.wb_en = (opcode != 4'b1010) && (opcode != 4'b1000);
                use_src1       = (opcode != 4'b1101) && (opcode != 4'b1111);
                use_src2       = !instr[25];
                case (opcode)
                    4'b1101: ctrl_dec.exe_cmd = 4'b0001;
                    4'b1111: ctrl_dec.exe_cmd = 4'b1001;
                    4'b0100: ctrl_dec.exe_cmd = 4'b0010;
                    4'b0101: ctrl_dec.exe_cmd = 4'b0011;
                    4'b0010: ctrl_dec.exe_cmd = 4'b0100;
                    4'b0110: ctrl_dec.exe_cmd = 4'b0101;
                    4'b0000: ctrl_dec.exe_cmd = 4'b0110;
                    4'b1100: ctrl_dec.exe_cmd = 4'b0111;
                    4'b0001: ctrl_dec.exe_cmd = 4'b1000;
                    4'b1010: ctrl_dec.exe_cmd = 4'b0100;
                    4'b1000: ctrl_dec.exe_cmd = 4'b0110;
                    default: ctrl_dec.exe_cmd = 4'b0000;
                endcase
            end
            MODE_MEM: begin
                ctrl_dec.exe_cmd = 4'b0010;
                ctrl_dec.mem_r   = instr[20];
                ctrl_dec.wb_en   = instr[20];
                ctrl_dec.mem_w   = !instr[20];
                use_src2         = !instr[20];
            end
            MODE_BR: begin
                ctrl_dec.b = 1'b1;
                use_src1   = 1'b0;
            end
            default: ;
        endcase
    end

    // Source indices; stores read the data register through the Rd field.
    assign src1 = RA_W'(instr[19:16]);
    assign src2 = ctrl_dec.mem_w ? RA_W'(instr[15:12]) : RA_W'(instr[3:0]);

    // Register-file reads with optional same-cycle write-back bypass.
    assign rd1 = (WB_BYPASS && bus.wb_wb_en && bus.wb_dest == src1) ? bus.wb_value : rf_q[src1];
    assign rd2 = (WB_BYPASS && bus.wb_wb_en && bus.wb_dest == src2) ? bus.wb_value : rf_q[src2];

    // RAW hazard against writers still in EXE or MEM.
    always_comb begin
        hazard = 1'b0;
        if (bus.in_valid && cond_ok) begin
            hazard = (use_src1 && ((bus.exe_wb_en && bus.exe_dest == src1) ||
                                   (bus.mem_wb_en && bus.mem_dest == src1))) ||
                     (use_src2 && ((bus.exe_wb_en && bus.exe_dest == src2) ||
                                   (bus.mem_wb_en && bus.mem_dest == src2)));
        end
    end

    // ID/EX next state: flush beats stall, stall beats hazard, then load.
    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d.ctrl  = '0;
            idex_d.valid = 1'b0;
        end else if (!bus.stall) begin
            if (hazard) begin
                idex_d.ctrl  = '0;
                idex_d.valid = 1'b0;
            end else begin
                idex_d.ctrl          = (bus.in_valid && cond_ok) ? ctrl_dec : '0;
                idex_d.valid         = bus.in_valid && cond_ok;
                idex_d.val_rn        = rd1;
                idex_d.val_rm        = rd2;
                idex_d.dest          = RA_W'(instr[15:12]);
                idex_d.imm           = instr[25];
                idex_d.shift_operand = instr[11:0];
                idex_d.signed_imm    = instr[23:0];
                idex_d.pc            = bus.pc_in;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    // Register file write port.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this array is deliberately reset; reset must leave every register reading zero.
        if (!rst) begin
            for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
        end else if (bus.wb_wb_en && (32'(bus.wb_dest) < REG_N)) begin
            rf_q[bus.wb_dest] <= bus.wb_value;
        end
    end

    assign bus.hazard        = hazard;
    assign bus.ctrl_out      = idex_q.ctrl;
    assign bus.out_valid     = idex_q.valid;
    assign bus.val_rn        = idex_q.val_rn;
    assign bus.val_rm        = idex_q.val_rm;
    assign bus.dest          = idex_q.dest;
    assign bus.imm           = idex_q.imm;
    assign bus.shift_operand = idex_q.shift_operand;
    assign bus.signed_imm    = idex_q.signed_imm;
    assign bus.pc_out        = idex_q.pc;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one instance with write-back bypass,
// one without, driven by the same stimulus.
module tb_id_stage_pipe;
    localparam int DATA_W = 32;
    localparam int REG_N  = 16;
    localparam int RA_W   = 4;

    localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD  R1,R2,R3
    localparam logic [31:0] I_ADD5  = 32'hE0851003; // ADD  R1,R5,R3
    localparam logic [31:0] I_MOV   = 32'hE3A01005; // MOV  R1,#5
    localparam logic [31:0] I_ADDEQ = 32'h00821003; // ADDEQ R1,R2,R3
    localparam logic [31:0] I_STR   = 32'hE5824000; // STR  R4,[R2]
    localparam logic [31:0] I_LDR   = 32'hE5924008; // LDR  R4,[R2,#8]
    localparam logic [31:0] I_B     = 32'hEA000010; // B    +0x10
    localparam logic [31:0] I_SUBS  = 32'hE2521001; // SUBS R1,R2,#1
    localparam logic [31:0] I_CMP   = 32'hE1520003; // CMP  R2,R3
    localparam logic [31:0] I_M11   = 32'hEC000000; // mode 11
    localparam logic [31:0] I_NV    = 32'hF0821003; // cond 1111

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              flush, stall, in_valid;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] pc_in;
    logic [3:0]        status;
    logic              wb_wb_en, exe_wb_en, mem_wb_en;
    logic [RA_W-1:0]   wb_dest, exe_dest, mem_dest;
    logic [DATA_W-1:0] wb_value;

    id_stage_pipe_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus_byp ();
    id_stage_pipe_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus_nob ();

    assign bus_byp.flush = flush;         assign bus_nob.flush = flush;
    assign bus_byp.stall = stall;         assign bus_nob.stall = stall;
    assign bus_byp.in_valid = in_valid;   assign bus_nob.in_valid = in_valid;
    assign bus_byp.instruction = instruction; assign bus_nob.instruction = instruction;
    assign bus_byp.pc_in = pc_in;         assign bus_nob.pc_in = pc_in;
    assign bus_byp.status = status;       assign bus_nob.status = status;
    assign bus_byp.wb_wb_en = wb_wb_en;   assign bus_nob.wb_wb_en = wb_wb_en;
    assign bus_byp.wb_dest = wb_dest;     assign bus_nob.wb_dest = wb_dest;
    assign bus_byp.wb_value = wb_value;   assign bus_nob.wb_value = wb_value;
    assign bus_byp.exe_wb_en = exe_wb_en; assign bus_nob.exe_wb_en = exe_wb_en;
    assign bus_byp.exe_dest = exe_dest;   assign bus_nob.exe_dest = exe_dest;
    assign bus_byp.mem_wb_en = mem_wb_en; assign bus_nob.mem_wb_en = mem_wb_en;
    assign bus_byp.mem_dest = mem_dest;   assign bus_nob.mem_dest = mem_dest;

    id_stage_pipe #(.DATA_W(DATA_W), .REG_N(REG_N), .WB_BYPASS(1'b1)) dut_byp (
        .clk (clk), .rst (rst), .bus (bus_byp.slave)
    );
    id_stage_pipe #(.DATA_W(DATA_W), .REG_N(REG_N), .WB_BYPASS(1'b0)) dut_nob (
        .clk (clk), .rst (rst), .bus (bus_nob.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; stall = 0; in_valid = 0; instruction = '0; pc_in = '0; status = '0;
        wb_wb_en = 0; wb_dest = '0; wb_value = '0;
        exe_wb_en = 0; exe_dest = '0; mem_wb_en = 0; mem_dest = '0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [DATA_W-1:0] pc);
        in_valid = 1; instruction = ins; pc_in = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        #2;
        check("rst_ctrl",  bus_byp.ctrl_out, 9'h000);
        check("rst_valid", bus_byp.out_valid, 1'b0);
        check("rst_pc",    bus_byp.pc_out, 32'h0);
        step();
        check("rst_hold_valid", bus_byp.out_valid, 1'b0);
        rst = 1;

        // Write R3 then read it through ADD R1,R2,R3
        wb_wb_en = 1; wb_dest = 4'd3; wb_value = 32'h1234;
        step();
        wb_wb_en = 0;
        issue(I_ADD, 32'h100);
        #1 check("add_hazard", bus_byp.hazard, 1'b0);
        step();
        check("add_ctrl",   bus_byp.ctrl_out, 9'h011);
        check("add_valid",  bus_byp.out_valid, 1'b1);
        check("add_rm",     bus_byp.val_rm, 32'h1234);
        check("add_rn",     bus_byp.val_rn, 32'h0);
        check("add_dest",   bus_byp.dest, 4'd1);
        check("add_pc",     bus_byp.pc_out, 32'h100);
        check("add_imm",    bus_byp.imm, 1'b0);
        check("add_shop",   bus_byp.shift_operand, 12'h003);
        check("add_simm",   bus_byp.signed_imm, 24'h821003);
        check("nob_add_rm", bus_nob.val_rm, 32'h1234);

        // Same-cycle write/read of R5, with and without bypass
        in_valid = 0;
        wb_wb_en = 1; wb_dest = 4'd5; wb_value = 32'h11;
        step();
        wb_value = 32'hA5;
        issue(I_ADD5, 32'h104);
        step();
        check("byp_rn", bus_byp.val_rn, 32'hA5);
        check("nob_rn", bus_nob.val_rn, 32'h11);
        wb_wb_en = 0;
        step();
        check("nob_rn_after", bus_nob.val_rn, 32'hA5);

        // Hazards from EXE and MEM writers
        issue(I_ADD, 32'h108);
        exe_wb_en = 1; exe_dest = 4'd2;
        #1 check("haz_exe_rn", bus_byp.hazard, 1'b1);
        step();
        check("haz_bubble_valid", bus_byp.out_valid, 1'b0);
        check("haz_bubble_ctrl",  bus_byp.ctrl_out, 9'h000);
        exe_wb_en = 0;
        mem_wb_en = 1; mem_dest = 4'd3;
        #1 check("haz_mem_rm", bus_byp.hazard, 1'b1);
        mem_wb_en = 0;
        #1 check("haz_mem_off", bus_byp.hazard, 1'b0);
        exe_wb_en = 1; exe_dest = 4'd0;
        issue(I_MOV, 32'h10C);
        #1 check("mov_no_haz", bus_byp.hazard, 1'b0);
        step();
        check("mov_ctrl",  bus_byp.ctrl_out, 9'h009);
        check("mov_imm",   bus_byp.imm, 1'b1);
        check("mov_shop",  bus_byp.shift_operand, 12'h005);

        // Condition codes: failing EQ suppresses hazard and control
        exe_dest = 4'd2;
        issue(I_ADDEQ, 32'h110);
        status = 4'b0000;
        #1 check("eq_fail_haz", bus_byp.hazard, 1'b0);
        step();
        check("eq_fail_ctrl",  bus_byp.ctrl_out, 9'h000);
        check("eq_fail_valid", bus_byp.out_valid, 1'b0);
        exe_wb_en = 0;
        status = 4'b0100;
        step();
        check("eq_pass_ctrl",  bus_byp.ctrl_out, 9'h011);
        check("eq_pass_valid", bus_byp.out_valid, 1'b1);
        status = 4'b0000;

        // Memory, branch and special decodes
        exe_wb_en = 1; exe_dest = 4'd4;
        issue(I_STR, 32'h114);
        #1 check("str_haz", bus_byp.hazard, 1'b1);
        exe_wb_en = 0;
        step();
        check("str_ctrl", bus_byp.ctrl_out, 9'h014);
        issue(I_LDR, 32'h118);
        step();
        check("ldr_ctrl", bus_byp.ctrl_out, 9'h013);
        check("ldr_dest", bus_byp.dest, 4'd4);
        issue(I_B, 32'h11C);
        step();
        check("b_ctrl", bus_byp.ctrl_out, 9'h080);
        check("b_simm", bus_byp.signed_imm, 24'h000010);
        issue(I_SUBS, 32'h120);
        step();
        check("subs_ctrl", bus_byp.ctrl_out, 9'h121);
        issue(I_CMP, 32'h124);
        step();
        check("cmp_ctrl", bus_byp.ctrl_out, 9'h120);
        issue(I_M11, 32'h128);
        step();
        check("m11_ctrl",  bus_byp.ctrl_out, 9'h000);
        check("m11_valid", bus_byp.out_valid, 1'b1);
        issue(I_NV, 32'h12C);
        step();
        check("nv_valid", bus_byp.out_valid, 1'b0);
        issue(I_ADD, 32'h130);
        in_valid = 0;
        step();
        check("invalid_valid", bus_byp.out_valid, 1'b0);

        // Stall, stall-with-hazard, flush+stall, flush alone
        issue(I_ADD, 32'h200);
        step();
        check("pre_stall_valid", bus_byp.out_valid, 1'b1);
        stall = 1;
        issue(I_MOV, 32'h204);
        step();
        check("stall_ctrl", bus_byp.ctrl_out, 9'h011);
        check("stall_pc",   bus_byp.pc_out, 32'h200);
        issue(I_ADD, 32'h208);
        exe_wb_en = 1; exe_dest = 4'd2;
        #1 check("stall_haz", bus_byp.hazard, 1'b1);
        step();
        check("stall_haz_valid", bus_byp.out_valid, 1'b1);
        check("stall_haz_pc",    bus_byp.pc_out, 32'h200);
        exe_wb_en = 0;
        flush = 1;
        step();
        check("flush_stall_valid", bus_byp.out_valid, 1'b0);
        check("flush_stall_ctrl",  bus_byp.ctrl_out, 9'h000);
        flush = 0; stall = 0;
        step();
        check("reload_valid", bus_byp.out_valid, 1'b1);
        flush = 1;
        step();
        check("flush_valid", bus_byp.out_valid, 1'b0);
        flush = 0;

        // Asynchronous reset between edges while holding a valid ADD
        issue(I_ADD, 32'h300);
        step();
        check("pre_rst_valid", bus_byp.out_valid, 1'b1);
        #2 rst = 0;
        #1;
        check("arst_valid", bus_byp.out_valid, 1'b0);
        check("arst_ctrl",  bus_byp.ctrl_out, 9'h000);
        check("arst_rm",    bus_byp.val_rm, 32'h0);
        check("arst_pc",    bus_byp.pc_out, 32'h0);
        #1 rst = 1;
        step();
        check("post_rst_valid", bus_byp.out_valid, 1'b1);
        check("post_rst_ctrl",  bus_byp.ctrl_out, 9'h011);
        check("post_rst_r3",    bus_byp.val_rm, 32'h0);
        for (int i = 0; i < REG_N; i++) begin
            instruction = 32'hE0801000 | (32'(i) << 16) | 32'(i);
            step();
            check($sformatf("rf_clr_rn_%0d", i), bus_nob.val_rn, 32'h0);
            check($sformatf("rf_clr_rm_%0d", i), bus_byp.val_rm, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
